// File: rtl/mv_pwm_generator.sv
// Complementary PWM output stage driven by the PID manipulation value.
// Optional macro PWM_DEADTIME_EN builds the dead-time gate FSM; without it the gates are raw/~raw.
`timescale 1ns/1ps
module mv_pwm_generator #(
    parameter int unsigned CNT_NB     = 16,
    parameter int unsigned DEAD_NB    = 8,
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic signed [31:0]  i_mv,
    input  logic [CNT_NB-1:0]   i_period,
    input  logic [DEAD_NB-1:0]  i_dead,
    output logic                o_pwm_h,
    output logic                o_pwm_l,
    output logic [CNT_NB-1:0]   o_duty,
    output logic                o_period_start,
    output logic                o_sat
);

    logic [CNT_NB-1:0] cnt;
    logic [CNT_NB-1:0] period_q;
    logic [CNT_NB-1:0] duty_q;
    logic              load_pend;

    logic              load_c;
    logic              raw_c;
    logic [CNT_NB-1:0] period_new_c;
    logic [CNT_NB-1:0] duty_new_c;
    logic              sat_new_c;
    logic [31:0]       mv_u;

    assign mv_u         = i_mv;
    assign load_c       = i_en && (load_pend || (cnt == period_q - CNT_NB'(1)));
    assign raw_c        = (cnt < duty_q);
    assign period_new_c = (i_period < CNT_NB'(MIN_PERIOD)) ? CNT_NB'(MIN_PERIOD) : i_period;
    assign o_duty       = duty_q;

    // Clamp the signed MV into [0, new period]
    always_comb begin
        duty_new_c = mv_u[CNT_NB-1:0];
        sat_new_c  = 1'b0;
        if (i_mv[31]) begin
            duty_new_c = '0;
            sat_new_c  = 1'b1;
        end else if (mv_u > 32'(period_new_c)) begin
            duty_new_c = period_new_c;
            sat_new_c  = 1'b1;
        end
    end

    // Period counter and shadow registers, reloaded only at period boundaries
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt            <= '0;
            period_q       <= CNT_NB'(MIN_PERIOD);
            duty_q         <= '0;
            load_pend      <= 1'b1;
            o_period_start <= 1'b0;
            o_sat          <= 1'b0;
        end else if (!i_en) begin
            cnt            <= '0;
            load_pend      <= 1'b1;
            o_period_start <= 1'b0;
        end else if (load_c) begin
            cnt            <= '0;
            load_pend      <= 1'b0;
            o_period_start <= 1'b1;
            period_q       <= period_new_c;
            duty_q         <= duty_new_c;
            o_sat          <= sat_new_c;
        end else begin
            cnt            <= cnt + CNT_NB'(1);
            o_period_start <= 1'b0;
        end
    end

`ifdef PWM_DEADTIME_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOW, S_DEAD_LH, S_HIGH, S_DEAD_HL
    } state_t;

    state_t             state;
    logic [DEAD_NB-1:0] dead_q;
    logic [DEAD_NB-1:0] dcnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dead_q <= '0;
        end else if (load_c) begin
            dead_q <= i_dead;
        end
    end

    // Gate FSM: both gates are off during every dead interval
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            dcnt    <= '0;
            o_pwm_h <= 1'b0;
            o_pwm_l <= 1'b0;
        end else if (!i_en) begin
            state   <= S_IDLE;
            o_pwm_h <= 1'b0;
            o_pwm_l <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state   <= S_LOW;
                    o_pwm_h <= 1'b0;
                    o_pwm_l <= 1'b1;
                end
                S_LOW: begin
                    if (raw_c) begin
                        o_pwm_l <= 1'b0;
                        if (dead_q == '0) begin
                            state   <= S_HIGH;
                            o_pwm_h <= 1'b1;
                        end else begin
                            state <= S_DEAD_LH;
                            dcnt  <= dead_q;
                        end
                    end
                end
                S_DEAD_LH: begin
                    if (!raw_c) begin
                        state   <= S_LOW;
                        o_pwm_l <= 1'b1;
                    end else if (dcnt == DEAD_NB'(1)) begin
                        state   <= S_HIGH;
                        o_pwm_h <= 1'b1;
                    end else begin
                        dcnt <= dcnt - DEAD_NB'(1);
                    end
                end
                S_HIGH: begin
                    if (!raw_c) begin
                        o_pwm_h <= 1'b0;
                        if (dead_q == '0) begin
                            state   <= S_LOW;
                            o_pwm_l <= 1'b1;
                        end else begin
                            state <= S_DEAD_HL;
                            dcnt  <= dead_q;
                        end
                    end
                end
                S_DEAD_HL: begin
                    if (raw_c) begin
                        state   <= S_HIGH;
                        o_pwm_h <= 1'b1;
                    end else if (dcnt == DEAD_NB'(1)) begin
                        state   <= S_LOW;
                        o_pwm_l <= 1'b1;
                    end else begin
                        dcnt <= dcnt - DEAD_NB'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    o_pwm_h <= 1'b0;
                    o_pwm_l <= 1'b0;
                end
            endcase
        end
    end
`else
    logic dead_unused;
    assign dead_unused = ^i_dead;

    // Plain complementary gates, one clock behind raw
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pwm_h <= 1'b0;
            o_pwm_l <= 1'b0;
        end else if (!i_en) begin
            o_pwm_h <= 1'b0;
            o_pwm_l <= 1'b0;
        end else begin
            o_pwm_h <= raw_c;
            o_pwm_l <= ~raw_c;
        end
    end
`endif

endmodule

// File: tb/tb_mv_pwm_generator.sv
// Directed self-checking bench for mv_pwm_generator (expectations cover both PWM_DEADTIME_EN builds).
`timescale 1ns/1ps
module tb_mv_pwm_generator;

`ifdef PWM_DEADTIME_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [31:0] mv;
    logic [15:0]        period;
    logic [7:0]         dead;
    logic               pwm_h;
    logic               pwm_l;
    logic [15:0]        duty;
    logic               period_start;
    logic               sat;

    int tests   = 0;
    int failed  = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    mv_pwm_generator #(.CNT_NB(16), .DEAD_NB(8), .MIN_PERIOD(2)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_mv          (mv),
        .i_period      (period),
        .i_dead        (dead),
        .o_pwm_h       (pwm_h),
        .o_pwm_l       (pwm_l),
        .o_duty        (duty),
        .o_period_start(period_start),
        .o_sat         (sat)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample n cycles starting with the current one, counting gate-high and start cycles
    task automatic measure(input int n, output int hs, output int ls, output int ss);
        hs = 0;
        ls = 0;
        ss = 0;
        for (int i = 0; i < n; i++) begin
            hs = hs + int'(pwm_h);
            ls = ls + int'(pwm_l);
            ss = ss + int'(period_start);
            if (pwm_h && pwm_l) overlap++;
            step();
        end
    endtask

    task automatic wait_start(input string tag);
        int found;
        found = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (period_start === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs, ls, ss;
        rst    = 1'b0;
        en     = 1'b0;
        mv     = 32'sd0;
        period = 16'd10;
        dead   = 8'd0;
        #1 rst = 1'b1;
        #10;
        chk("reset_h", 32'(pwm_h), 32'd0);
        chk("reset_l", 32'(pwm_l), 32'd0);
        chk("reset_duty", 32'(duty), 32'd0);
        chk("reset_sat", 32'(sat), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("disabled_l", 32'(pwm_l), 32'd0);
        chk("disabled_start", 32'(period_start), 32'd0);

        // Basic PWM, period 10, duty 4
        mv = 32'sd4;
        en = 1'b1;
        step();
        chk("first_start", 32'(period_start), 32'd1);
        chk("first_duty", 32'(duty), 32'd4);
        chk("first_l", 32'(pwm_l), 32'd1);
        chk("first_h", 32'(pwm_h), 32'd0);
        chk("first_sat", 32'(sat), 32'd0);
        measure(10, hs, ls, ss);
        chk("p1_h_cycles", 32'(hs), 32'd4);
        chk("p1_l_cycles", 32'(ls), 32'd6);
        chk("p1_starts", 32'(ss), 32'd1);
        chk("p2_start", 32'(period_start), 32'd1);
        measure(10, hs, ls, ss);
        chk("p2_h_cycles", 32'(hs), 32'd4);
        chk("p2_l_cycles", 32'(ls), 32'd6);
        chk("p3_start", 32'(period_start), 32'd1);

        // Mid-period MV change is deferred to the next boundary
        step();
        step();
        mv = 32'sd7;
        chk("midchange_duty_held", 32'(duty), 32'd4);
        measure(8, hs, ls, ss);
        chk("midchange_h_rest", 32'(hs), 32'd3);
        chk("midchange_no_start", 32'(ss), 32'd0);
        chk("midchange_start", 32'(period_start), 32'd1);
        chk("midchange_new_duty", 32'(duty), 32'd7);
        measure(10, hs, ls, ss);
        chk("duty7_h_cycles", 32'(hs), 32'd7);
        chk("duty7_l_cycles", 32'(ls), 32'd3);

        // Negative MV clamps to 0, oversize MV clamps to the period
        mv = -32'sd5;
        wait_start("neg_start_seen");
        chk("neg_duty", 32'(duty), 32'd0);
        chk("neg_sat", 32'(sat), 32'd1);
        mv = 32'sd25;
        measure(10, hs, ls, ss);
        chk("neg_h_cycles", 32'(hs), 32'd0);
        chk("neg_l_cycles", 32'(ls), 32'd10);
        chk("big_duty", 32'(duty), 32'd10);
        chk("big_sat", 32'(sat), 32'd1);
        measure(10, hs, ls, ss);
        chk("big_h_cycles_first", 32'(hs), 32'd9);
        chk("big_l_cycles_first", 32'(ls), 32'd1);
        measure(10, hs, ls, ss);
        chk("big_h_cycles", 32'(hs), 32'd10);
        chk("big_l_cycles", 32'(ls), 32'd0);
        chk("prereset_h", 32'(pwm_h), 32'd1);

        // Asynchronous reset mid-pulse
        #2 rst = 1'b1;
        #1;
        chk("async_rst_h", 32'(pwm_h), 32'd0);
        chk("async_rst_l", 32'(pwm_l), 32'd0);
        chk("async_rst_duty", 32'(duty), 32'd0);
        chk("async_rst_sat", 32'(sat), 32'd0);
        en = 1'b0;
        #3 rst = 1'b0;
        step();
        chk("post_rst_h", 32'(pwm_h), 32'd0);

        // Period 20, duty 8, dead time 3
        period = 16'd20;
        mv     = 32'sd8;
        dead   = 8'd3;
        en     = 1'b1;
        step();
        chk("dt_start", 32'(period_start), 32'd1);
        measure(20, hs, ls, ss);
        chk("dt_p1_h_cycles", 32'(hs), DT ? 32'd5 : 32'd8);
        chk("dt_p1_l_cycles", 32'(ls), DT ? 32'd9 : 32'd12);
        chk("dt_p1_both_off", 32'(20 - hs - ls), DT ? 32'd6 : 32'd0);
        measure(20, hs, ls, ss);
        chk("dt_p2_h_cycles", 32'(hs), DT ? 32'd5 : 32'd8);
        chk("dt_p2_l_cycles", 32'(ls), DT ? 32'd9 : 32'd12);
        chk("dt_p2_starts", 32'(ss), 32'd1);

        // Pulse shorter than the dead time
        mv   = 32'sd2;
        dead = 8'd5;
        wait_start("short_start_seen");
        measure(20, hs, ls, ss);
        chk("short_h_cycles", 32'(hs), DT ? 32'd0 : 32'd2);
        chk("short_l_cycles", 32'(ls), 32'd18);

        // Period below the minimum is raised; MV above it saturates
        period = 16'd0;
        mv     = 32'sd5;
        wait_start("minp_start_seen");
        chk("minp_duty", 32'(duty), 32'd2);
        chk("minp_sat", 32'(sat), 32'd1);
        measure(4, hs, ls, ss);
        chk("minp_starts", 32'(ss), 32'd2);

        // Disable forces gates off and holds the shadow registers
        en = 1'b0;
        step();
        chk("dis_h", 32'(pwm_h), 32'd0);
        chk("dis_l", 32'(pwm_l), 32'd0);
        chk("dis_duty_held", 32'(duty), 32'd2);
        en = 1'b1;
        step();
        chk("reen_start", 32'(period_start), 32'd1);

        chk("gate_overlap", 32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mv_pwm_generator.md
Name: mv_pwm_generator

Overview:
Output stage placed directly downstream of PID_Controller. Consumes the 32-bit signed manipulation value (o_mv) and produces a complementary, dead-time-protected PWM pair for a half-bridge driver. The duty cycle is the MV clamped to [0, period]. Period, duty and dead time are double-buffered and update only at period boundaries, so no glitch pulses occur.

Parameters:
CNT_NB, 16, width of the period counter and duty registers
DEAD_NB, 8, width of the dead-time counter
MIN_PERIOD, 2, smallest period accepted; smaller i_period values are raised to this

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous, active-high reset
i_en  input  1  run enable; low forces both outputs off
i_mv  input  32  signed manipulation value from PID_Controller
i_period  input  CNT_NB  PWM period in clocks (shadowed)
i_dead  input  DEAD_NB  dead time in clocks (shadowed)
o_pwm_h  output  1  high-side gate, registered
o_pwm_l  output  1  low-side gate, registered
o_duty  output  CNT_NB  currently active clamped duty
o_period_start  output  1  one-cycle pulse when a new period begins
o_sat  output  1  sticky per period: the last loaded MV was clamped

Behaviour:
- Reset (async, i_rst=1): cnt=0; period_q=MIN_PERIOD; duty_q=0; dead_q=0; state=S_IDLE; load_pend=1; all outputs 0.
- Shadow load occurs on the clock edge when i_en=1 and either load_pend=1 or cnt==period_q-1. On that edge:
  - cnt<=0; load_pend<=0; o_period_start<=1 for one cycle.
  - period_q <= max(i_period, MIN_PERIOD); dead_q <= i_dead.
  - duty_q <= clamp(i_mv): 0 if i_mv<0; the new period_q if i_mv > new period_q (unsigned compare after sign check); otherwise i_mv[CNT_NB-1:0].
  - o_sat <= 1 if clamped, else 0. o_duty mirrors duty_q.
- Otherwise, when i_en=1, cnt increments by 1. cnt never exceeds period_q-1.
- raw = (cnt < duty_q), combinational. duty 0 gives raw always 0; duty==period gives raw always 1.
- Gate FSM (registered outputs; h=o_pwm_h, l=o_pwm_l):
  - S_IDLE (h=0, l=0): when i_en=1, go to S_LOW.
  - S_LOW (h=0, l=1): if raw=1, go to S_DEAD_LH with dcnt<=dead_q; if dead_q==0, go directly to S_HIGH.
  - S_DEAD_LH (0,0): dcnt decrements. At dcnt==1 go to S_HIGH. If raw drops first, go to S_LOW immediately; this is safe because high never turned on.
  - S_HIGH (1,0): if raw=0, go to S_DEAD_HL (same dead rules), or directly to S_LOW if dead_q==0.
  - S_DEAD_HL (0,0): at dcnt==1 go to S_LOW. If raw rises first, go to S_HIGH.
- Latency: an output edge follows the raw edge by 1 clock plus dead_q clocks.
- Invariant: h and l are never 1 in the same cycle, in any state or on any transition.
- i_en=0 (sampled, synchronous): state<=S_IDLE; cnt<=0; load_pend<=1; h=l=0 on the next edge. Shadow registers are held.
- When i_en rises: the first enabled edge performs a shadow load. The FSM leaves S_IDLE on that same edge.
- Mid-period changes to i_mv, i_period or i_dead have no effect until the next boundary.
- Asserting i_rst mid-pulse clears h and l immediately, without waiting for a clock.

Optional Feature:
Macro PWM_DEADTIME_EN.
- Defined: the dead-time FSM operates as described above.
- Undefined: i_dead and the dead counter are not built. o_pwm_h = registered raw. o_pwm_l = registered ~raw while enabled, and 0 in S_IDLE. The 1-clock latency is kept.

Test Plan:
1. Reset with i_rst=1 mid-run (h=1) -> h, l, o_duty, o_sat drop to 0 asynchronously, within the same cycle.
2. i_period=10, i_dead=0, i_mv=4, i_en=1 -> o_period_start every 10 clocks; h high 4 clocks and l high 6 clocks per period; o_sat=0.
3. i_period=10, i_mv=-5, then i_mv=25 -> first period: o_duty=0, h never high, o_sat=1. Next period: o_duty=10, l low for the whole period after the first transition, o_sat=1.
4. i_period=20, i_mv=8, i_dead=3 -> after each raw edge, both gates 0 for exactly 3 clocks. h high 8-3=5 clocks, l high 12-3=9 clocks per period. h&l never 1 (assertion check).
5. Change i_mv from 4 to 7 at cnt=2 with i_period=10 -> current period keeps duty 4; o_duty=7 starting at the next o_period_start.
6. i_dead=5, i_mv=2 (pulse shorter than dead) -> h never asserts. FSM returns S_DEAD_LH to S_LOW; l off for exactly 2 clocks. With PWM_DEADTIME_EN undefined: h high 2 clocks, l = its complement.
